// File: rtl/calc_pkg.sv
// Purpose: shared keycode fields, operator codes, ALU op encodings and FSM states for the calculator sequencer.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package calc_pkg;

  localparam int KEY_W  = 5;
  localparam int DATA_W = 4;
  localparam int OPC_W  = 3;

  // Operator codes carried in keycode data[2:0] when num=0.
  localparam logic [OPC_W-1:0] OPC_NOTHING = 3'b000;
  localparam logic [OPC_W-1:0] OPC_CLEAR   = 3'b001;
  localparam logic [OPC_W-1:0] OPC_PLUS    = 3'b010;
  localparam logic [OPC_W-1:0] OPC_MUL     = 3'b011;
  localparam logic [OPC_W-1:0] OPC_EQUALS  = 3'b100;

  typedef enum logic [1:0] {
    ALU_NONE = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_MUL  = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_DECODE   = 2'b01,
    ST_ALU_WAIT = 2'b10
  } state_t;

  typedef struct packed {
    logic              num;
    logic [DATA_W-1:0] data;
  } key_t;

  // Pending-op value an operator key leaves behind; EQUALS and unknown codes map to NONE.
  function automatic alu_op_t opc_to_alu(input logic [OPC_W-1:0] opc);
    case (opc)
      OPC_PLUS: return ALU_ADD;
      OPC_MUL:  return ALU_MUL;
      default:  return ALU_NONE;
    endcase
  endfunction

  function automatic logic is_clear(input key_t k);
    return !k.num && (k.data[OPC_W-1:0] == OPC_CLEAR);
  endfunction

endpackage

// File: rtl/calc_key_fifo.sv
// Purpose: small synchronous FIFO (DEPTH x WIDTH) with push, pop, flush, full and empty.
// Latency: a pushed entry is visible at pop_data the cycle after the push edge.
// Backpressure: push while full is discarded unless a pop happens in the same cycle.
// Ports: clock/reset (async, active-high); push/push_data write side; pop/pop_data
//        read side (pop_data shows the head combinationally); flush empties it; full/empty status.
module calc_key_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  input  logic             flush,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_ok    = pop && !empty;
  // When full, a simultaneous pop frees the head slot, which the push may overwrite
  // because the head is read out before the edge.
  assign wr_ok    = push && (!full || rd_ok);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (wr_ok && !flush) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/calc_op_sequencer.sv
// Purpose: calculator sequencer - buffers keys, decodes digits/operators, holds X/Y/op, drives ALU jobs and the display.
// Latency: digit with empty buffer: key sampled at E, popped at E+1, value updated at E+2; ALU jobs wait for alu_ack.
// Backpressure: keys queue in a KEY_FIFO_DEPTH buffer; a key arriving while full is dropped and key_dropped pulses.
// Ports: clock, reset (async, active-high); newKey/keycode key input; alu_req/alu_op/alu_a/alu_b job
//        request held until alu_ack with alu_result/alu_ovf; value display; busy, sticky error, key_dropped pulse.
module calc_op_sequencer
  import calc_pkg::*;
#(
  parameter int KEY_FIFO_DEPTH = 4,
  parameter int WIDTH          = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             newKey,
  input  logic [4:0]       keycode,
  output logic             alu_req,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic             alu_ack,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_ovf,
  output logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             error,
  output logic             key_dropped
);

  key_t       in_key;
  key_t       fifo_head;
  logic       clear_hit;
  logic       push;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;

  state_t     state_q, state_d;
  key_t       key_q, key_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, value_q, value_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  alu_op_t    op_q, op_d, aop_q, aop_d, key_op;
  logic       fresh_q, fresh_d, err_q, err_d, req_q, req_d, dropped_q;
  logic       key_is_eq;
  logic [WIDTH-1:0] x_entry;

  assign in_key    = key_t'(keycode);
  // CLEAR never enters the buffer: it acts on the edge it is sampled.
  assign clear_hit = newKey && is_clear(in_key);
  assign push      = newKey && !clear_hit;
  assign pop       = (state_q == ST_IDLE) && !fifo_empty && !clear_hit;

  calc_key_fifo #(
    .DEPTH (KEY_FIFO_DEPTH),
    .WIDTH (KEY_W)
  ) u_key_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (in_key),
    .pop       (pop),
    .pop_data  (fifo_head),
    .flush     (clear_hit),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // First digit after an operator/result starts a new entry instead of shifting.
  assign x_entry   = fresh_q ? {{(WIDTH-DATA_W){1'b0}}, key_q.data}
                             : {x_q[WIDTH-DATA_W-1:0], key_q.data};
  assign key_op    = opc_to_alu(key_q.data[OPC_W-1:0]);
  assign key_is_eq = (key_q.data[OPC_W-1:0] == OPC_EQUALS);

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    x_d     = x_q;
    y_d     = y_q;
    op_d    = op_q;
    fresh_d = fresh_q;
    err_d   = err_q;
    value_d = value_q;
    req_d   = req_q;
    aop_d   = aop_q;
    a_d     = a_q;
    b_d     = b_q;

    if (clear_hit) begin
      // CLEAR outranks a same-cycle alu_ack; the late result is discarded.
      state_d = ST_IDLE;
      x_d     = '0;
      y_d     = '0;
      op_d    = ALU_NONE;
      fresh_d = 1'b0;
      err_d   = 1'b0;
      value_d = '0;
      req_d   = 1'b0;
      aop_d   = ALU_NONE;
      a_d     = '0;
      b_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            key_d   = fifo_head;
            state_d = ST_DECODE;
          end
        end
        ST_DECODE: begin
          state_d = ST_IDLE;
          if (key_q.num) begin
            x_d     = x_entry;
            value_d = x_entry;
            fresh_d = 1'b0;
          end else if (key_op != ALU_NONE || key_is_eq) begin
            if (op_q != ALU_NONE) begin
              req_d   = 1'b1;
              aop_d   = op_q;
              a_d     = y_q;
              b_d     = x_q;
              state_d = ST_ALU_WAIT;
            end else if (key_is_eq) begin
              value_d = x_q;
              fresh_d = 1'b1;
            end else begin
              y_d     = x_q;
              op_d    = key_op;
              fresh_d = 1'b1;
              value_d = x_q;
            end
          end
        end
        ST_ALU_WAIT: begin
          if (alu_ack) begin
            req_d   = 1'b0;
            y_d     = alu_result;
            err_d   = err_q | alu_ovf;
            value_d = alu_result;
            fresh_d = 1'b1;
            // key_q still holds the operator that launched this job.
            op_d    = key_op;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      key_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      op_q      <= ALU_NONE;
      fresh_q   <= 1'b0;
      err_q     <= 1'b0;
      value_q   <= '0;
      req_q     <= 1'b0;
      aop_q     <= ALU_NONE;
      a_q       <= '0;
      b_q       <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      x_q       <= x_d;
      y_q       <= y_d;
      op_q      <= op_d;
      fresh_q   <= fresh_d;
      err_q     <= err_d;
      value_q   <= value_d;
      req_q     <= req_d;
      aop_q     <= aop_d;
      a_q       <= a_d;
      b_q       <= b_d;
      dropped_q <= push && fifo_full && !pop;
    end
  end

  assign alu_req     = req_q;
  assign alu_op      = aop_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign value       = value_q;
  assign error       = err_q;
  assign key_dropped = dropped_q;
  assign busy        = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Purpose: directed self-checking bench for calc_op_sequencer with a hand-driven ALU.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: ALU ack timing is chosen per step to exercise buffering and drops.
module tb_calc_op_sequencer;

  localparam int W = 16;
  localparam logic [4:0] K_CLR  = 5'b00001;
  localparam logic [4:0] K_PLUS = 5'b00010;
  localparam logic [4:0] K_MUL  = 5'b00011;
  localparam logic [4:0] K_EQ   = 5'b00100;

  logic         clock = 1'b0;
  logic         reset;
  logic         newKey;
  logic [4:0]   keycode;
  logic         alu_req;
  logic [1:0]   alu_op;
  logic [W-1:0] alu_a, alu_b;
  logic         alu_ack;
  logic [W-1:0] alu_result;
  logic         alu_ovf;
  logic [W-1:0] value;
  logic         busy, error, key_dropped;

  int   total = 0;
  int   bad = 0;
  int   req_starts = 0;
  int   drops = 0;
  int   base;
  logic req_prev = 1'b0;

  calc_op_sequencer #(.KEY_FIFO_DEPTH(4), .WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .newKey      (newKey),
    .keycode     (keycode),
    .alu_req     (alu_req),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_ack     (alu_ack),
    .alu_result  (alu_result),
    .alu_ovf     (alu_ovf),
    .value       (value),
    .busy        (busy),
    .error       (error),
    .key_dropped (key_dropped)
  );

  always #5 clock = ~clock;

  // Count ALU job launches and dropped-key pulses.
  always @(negedge clock) begin
    if (alu_req && !req_prev) req_starts++;
    req_prev = alu_req;
    if (key_dropped) drops++;
  end

  function automatic logic [4:0] dig(input int n);
    logic [4:0] k;
    k = {1'b1, 4'(n)};
    return k;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic key(input logic [4:0] c);
    newKey  = 1'b1;
    keycode = c;
    @(negedge clock);
    newKey  = 1'b0;
    keycode = 5'd0;
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 60 && !alu_req; i++) @(negedge clock);
    chk({tag, "_req"}, 32'(alu_req), 32'd1);
  endtask

  task automatic run_alu(input string tag, input int dly, input logic [1:0] eop,
                         input logic [W-1:0] ea, input logic [W-1:0] eb,
                         input logic [W-1:0] res, input logic ovf);
    wait_req(tag);
    chk({tag, "_op"}, 32'(alu_op), 32'(eop));
    chk({tag, "_a"}, 32'(alu_a), 32'(ea));
    chk({tag, "_b"}, 32'(alu_b), 32'(eb));
    tick(dly);
    chk({tag, "_held"}, 32'(alu_req), 32'd1);
    alu_ack    = 1'b1;
    alu_result = res;
    alu_ovf    = ovf;
    @(negedge clock);
    alu_ack    = 1'b0;
    alu_result = '0;
    alu_ovf    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; newKey = 1'b0; keycode = 5'd0;
    alu_ack = 1'b0; alu_result = '0; alu_ovf = 1'b0;
    tick(2);
    chk("rst_flags", 32'({alu_req, busy, error, key_dropped, alu_op}), 32'd0);
    chk("rst_value", 32'(value), 32'd0);
    chk("rst_ab", 32'({alu_a, alu_b}), 32'd0);
    reset = 1'b0;
    tick(1);

    // 1: digits entered one at a time into an empty buffer.
    key(dig(1)); tick(3);
    chk("t1_v1", 32'(value), 32'h1);
    key(dig(2)); tick(3);
    key(dig(3));
    chk("t1_busy_e", 32'(busy), 32'd1);
    tick(1);
    chk("t1_v_e1", 32'(value), 32'h12);
    chk("t1_busy_e1", 32'(busy), 32'd1);
    tick(1);
    chk("t1_v_e2", 32'(value), 32'h123);
    tick(1);
    chk("t1_busy_end", 32'(busy), 32'd0);

    // 2: 5 + 3 =
    key(K_CLR);
    chk("t2_clr_v", 32'(value), 32'd0);
    base = req_starts;
    key(dig(5)); key(K_PLUS); key(dig(3)); key(K_EQ);
    run_alu("t2", 4, 2'b01, 16'd5, 16'd3, 16'd8, 1'b0);
    tick(5);
    chk("t2_value", 32'(value), 32'h8);
    chk("t2_err", 32'(error), 32'd0);
    chk("t2_req_low", 32'(alu_req), 32'd0);
    chk("t2_jobs", 32'(req_starts - base), 32'd1);

    // 3: 2 * 3 + 4 =  (relies on op=NONE after the previous EQUALS)
    base = req_starts;
    key(dig(2)); key(K_MUL); key(dig(3)); key(K_PLUS); key(dig(4)); key(K_EQ);
    run_alu("t3a", 3, 2'b10, 16'd2, 16'd3, 16'd6, 1'b0);
    run_alu("t3b", 3, 2'b01, 16'd6, 16'd4, 16'd10, 1'b0);
    tick(5);
    chk("t3_value", 32'(value), 32'hA);
    chk("t3_jobs", 32'(req_starts - base), 32'd2);
    chk("t3_drops", 32'(drops), 32'd0);

    // 4: buffer overflow while an ALU job is outstanding.
    key(K_CLR);
    key(dig(7)); key(K_PLUS); key(dig(1)); key(K_PLUS);
    wait_req("t4");
    base = drops;
    key(dig(2)); key(dig(3)); key(K_MUL); key(dig(4)); key(dig(5)); key(K_EQ);
    tick(2);
    chk("t4_drops", 32'(drops - base), 32'd2);
    chk("t4_busy", 32'(busy), 32'd1);
    run_alu("t4a", 0, 2'b01, 16'd7, 16'd1, 16'd8, 1'b0);
    run_alu("t4b", 1, 2'b01, 16'd8, 16'h23, 16'h2B, 1'b0);
    tick(6);
    chk("t4_value", 32'(value), 32'h4);
    chk("t4_req_low", 32'(alu_req), 32'd0);
    chk("t4_idle", 32'(busy), 32'd0);

    // 5: CLEAR in the same cycle as alu_ack.
    key(K_EQ);
    wait_req("t5");
    chk("t5_op", 32'(alu_op), 32'd2);
    chk("t5_ab", 32'({alu_a, alu_b}), {16'h2B, 16'h4});
    newKey = 1'b1; keycode = K_CLR; alu_ack = 1'b1; alu_result = 16'hAC;
    @(negedge clock);
    newKey = 1'b0; keycode = 5'd0; alu_ack = 1'b0; alu_result = '0;
    chk("t5_req_low", 32'(alu_req), 32'd0);
    chk("t5_value", 32'(value), 32'd0);
    chk("t5_flags", 32'({busy, error}), 32'd0);
    alu_ack = 1'b1; alu_result = 16'h55;
    tick(1);
    alu_ack = 1'b0; alu_result = '0;
    tick(2);
    chk("t5_late_ack", 32'(value), 32'd0);
    base = req_starts;
    key(dig(3)); key(K_EQ);
    tick(6);
    chk("t5_eq_none", 32'(value), 32'h3);
    chk("t5_no_job", 32'(req_starts - base), 32'd0);

    // 6: overflow makes error sticky; reset mid-job; CLEAR clears error.
    key(dig(9)); key(K_MUL); key(dig(9)); key(K_EQ);
    run_alu("t6a", 2, 2'b10, 16'd9, 16'd9, 16'h2345, 1'b1);
    tick(2);
    chk("t6_value", 32'(value), 32'h2345);
    chk("t6_err", 32'(error), 32'd1);
    key(dig(1)); key(K_PLUS); key(dig(2)); key(K_EQ);
    run_alu("t6b", 1, 2'b01, 16'd1, 16'd2, 16'd3, 1'b0);
    tick(2);
    chk("t6_value2", 32'(value), 32'h3);
    chk("t6_err_sticky", 32'(error), 32'd1);
    key(K_PLUS); key(dig(4)); key(K_EQ);
    wait_req("t6c");
    #2 reset = 1'b1;
    #1;
    chk("t6_arst_flags", 32'({alu_req, busy, error, key_dropped, alu_op}), 32'd0);
    chk("t6_arst_value", 32'(value), 32'd0);
    chk("t6_arst_ab", 32'({alu_a, alu_b}), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    tick(2);
    chk("t6_post_rst", 32'({alu_req, busy, error}), 32'd0);
    key(dig(2)); key(K_MUL); key(dig(3)); key(K_EQ);
    run_alu("t6d", 0, 2'b10, 16'd2, 16'd3, 16'd6, 1'b1);
    tick(2);
    chk("t6d_err", 32'(error), 32'd1);
    key(K_CLR);
    chk("t6_clr_err", 32'(error), 32'd0);
    chk("t6_clr_value", 32'(value), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
